mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port; the other end of the address/MemWrite/data interface the control unit drives.
- Accepts one word read or write request at a time.
- Inserts a parameterised number of wait states, then returns ReadData with a one-cycle Ready pulse.
- Sits between the datapath's IorD address mux and a word-addressed RAM array held inside the block; stands in for instruction/data memory in simulation and FPGA builds.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH_WORDS, 256, number of words in the array; power of two.
- WAIT_CYCLES, 2, wait states between request accept and response; legal range 0..15.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe; sampled only in IDLE.
- MemWrite  in  1  1 = write, 0 = read; qualified by Req.
- Address  in  32  byte address from the datapath.
- WriteData  in  DATA_W  write data; qualified by Req & MemWrite.
- ReadData  out  DATA_W  read result; valid when Ready = 1, held until the next response.
- Ready  out  1  one-cycle response pulse.
- Err  out  1  valid with Ready: misaligned or out-of-range request.
- Busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (Reset_n = 0, asynchronous):
  - state = IDLE; ReadData = 0, Ready = 0, Err = 0, Busy = 0.
  - Wait counter = 0; latched request fields cleared.
  - Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP (enum in package).
- IDLE:
  - If Req = 1, latch Address, MemWrite and WriteData.
  - Next state = WAIT if WAIT_CYCLES > 0, else RESP. Counter loaded with WAIT_CYCLES-1.
  - If Req = 0, stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - When counter = 0, next state = RESP.
  - Req and input changes are ignored; only latched values are used.
- RESP:
  - Ready = 1 for exactly this cycle; next state = IDLE.
  - Read: ReadData = array[word index], registered so it is valid during the Ready cycle.
  - Write: array[word index] = latched WriteData at the end of this cycle; ReadData unchanged.
- Latency:
  - Req high in cycle t (in IDLE) gives Ready in cycle t+1+WAIT_CYCLES.
  - Minimum request spacing is WAIT_CYCLES+2 cycles. A Req in the RESP cycle is not accepted.
- Address decode:
  - word index = Address[log2(DEPTH_WORDS)+1:2].
  - Misaligned (Address[1:0] != 0) or out of range (Address >= DEPTH_WORDS*4): response still occurs with normal latency, with Err = 1 and Ready = 1.
  - On error, no array write occurs and ReadData is driven to 0.
- Err is 0 whenever Ready is 0.
- Read-after-write: a read to an address issued after a write's Ready returns the written data.
- Reset asserted mid-operation (WAIT or RESP before the clock edge): request aborted, no write committed, no Ready.
- Busy is combinational from state: 0 in IDLE, 1 otherwise.
- No combinational path from any input to any output.

Decomposition:
- Package mem_responder_pkg holds:
  - the state enum type {IDLE, WAIT, RESP}, 2 bits;
  - WAIT_W = 4 (counter width);
  - the error-code constants.
- One sub-module, mem_array: a synchronous single-port RAM with registered read, write enable, DEPTH_WORDS x DATA_W.
- The FSM, counter and address decode stay in mem_responder.

Test Plan:
- Reset then idle: Reset_n low 3 cycles, then high with Req = 0 for 10 cycles -> Ready = 0, Busy = 0, ReadData = 0 throughout.
- Write/read, WAIT_CYCLES = 2:
  - Req with MemWrite = 1, Address = 0x10, WriteData = 0xDEADBEEF at cycle t -> Ready at t+3, Err = 0.
  - Then a read of 0x10 -> Ready 3 cycles after accept, ReadData = 0xDEADBEEF.
- Zero wait states (WAIT_CYCLES = 0): read of 0x0 after writing 0x12345678 -> Ready exactly 1 cycle after Req, ReadData = 0x12345678.
- Errors:
  - Read at Address = 0x13 -> Ready at t+3, Err = 1, ReadData = 0.
  - Write to 0x400 (DEPTH_WORDS = 256) -> Err = 1, and a later read of 0x0 is unchanged.
- Busy rejection: Req held high continuously with different addresses -> only requests sampled in IDLE are accepted, one response per 4 cycles, Busy = 1 between accept and Ready.
- Reset mid-op: write to 0x20 of 0xA5A5A5A5, Reset_n pulsed low in the WAIT cycle -> no Ready; a subsequent read of 0x20 returns its prior value.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared types, constants and address-decode helper for the
//                memory-side responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait-state counter width (WAIT_CYCLES up to 15)
  localparam int WAIT_W = 4;

  // Error codes reported on Err alongside Ready
  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_DECODE = 1'b1;

  // A request is bad if it is not word aligned or lies beyond the array.
  // idx_w is the number of word-index bits, so the array spans 2^(idx_w+2) bytes.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned idx_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (idx_w + 2)) != 32'd0);
    return (misaligned || out_of_range) ? ERR_DECODE : ERR_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
//  Module      : mem_array
//  Description : Synchronous single-port RAM, DEPTH_WORDS x DATA_W, with a
//                registered read port that only updates on a read enable.
//                Array contents are never cleared by reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage write port; no reset so the array can map onto block RAM
  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; holds the last read value between read enables
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed memory responder. Accepts one read or write
//                request in IDLE, waits WAIT_CYCLES states, then pulses Ready
//                for one cycle with ReadData/Err. Bad addresses still get a
//                normal-latency response, flagged with Err and zero data.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Err,
  output logic              Busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Counter preload: WAIT_CYCLES-1 so that WAIT lasts exactly WAIT_CYCLES cycles
  localparam logic [WAIT_W-1:0] C_CNT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic                r_rd_zero;

  logic                w_accept;
  logic                w_to_resp;
  logic                w_in_err;
  logic                w_cur_we;
  logic                w_cur_err;
  logic [IDX_W-1:0]    w_ram_addr;
  logic                w_ram_re;
  logic                w_ram_we;
  logic [DATA_W-1:0]   w_ram_q;

  assign w_in_err = addr_err(Address, IDX_W);
  assign w_accept = (r_state == IDLE) && Req;

  // In IDLE the request comes straight from the ports (needed for the
  // zero-wait case); afterwards only the latched copy is used.
  assign w_cur_we   = (r_state == IDLE) ? MemWrite : r_we;
  assign w_cur_err  = (r_state == IDLE) ? w_in_err : r_err;
  assign w_ram_addr = (r_state == IDLE) ? Address[IDX_W+1:2] : r_idx;

  // RAM read is launched on the edge entering RESP so data is valid in RESP
  assign w_ram_re = w_to_resp && !w_cur_we && !w_cur_err;
  // Writes commit at the end of the RESP cycle, and never for bad addresses
  assign w_ram_we = (r_state == RESP) && r_we && !r_err;

  // Next-state decode and RESP-entry detection
  always_comb begin
    w_next    = r_state;
    w_to_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (Req) begin
          w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_to_resp = (w_next == RESP) && (r_state != RESP);
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture, wait counter and read-data zeroing flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_err     <= ERR_NONE;
      r_rd_zero <= 1'b1;
    end else begin
      if (w_accept) begin
        r_cnt   <= C_CNT_LOAD;
        r_idx   <= Address[IDX_W+1:2];
        r_we    <= MemWrite;
        r_wdata <= WriteData;
        r_err   <= w_in_err;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Only read responses touch ReadData; a bad read forces it to zero
      if (w_to_resp && !w_cur_we) begin
        r_rd_zero <= w_cur_err;
      end
    end
  end

  mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (IDX_W)
  ) u_mem_array (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_we ? r_idx : w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign Ready    = (r_state == RESP);
  assign Err      = Ready && r_err;
  assign Busy     = (r_state != IDLE);
  assign ReadData = r_rd_zero ? '0 : w_ram_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder with
//                WAIT_CYCLES = 2 (main) and WAIT_CYCLES = 0 (second instance).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  // Two-wait-state instance
  logic        req, mem_write, ready, err, busy;
  logic [31:0] address, wdata, rdata;

  // Zero-wait-state instance
  logic        req0, mem_write0, ready0, err0, busy0;
  logic [31:0] address0, wdata0, rdata0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
    .Clk(clk), .Reset_n(rst_n), .Req(req), .MemWrite(mem_write),
    .Address(address), .WriteData(wdata), .ReadData(rdata),
    .Ready(ready), .Err(err), .Busy(busy)
  );

  mem_responder #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(clk), .Reset_n(rst_n), .Req(req0), .MemWrite(mem_write0),
    .Address(address0), .WriteData(wdata0), .ReadData(rdata0),
    .Ready(ready0), .Err(err0), .Busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request on the WAIT_CYCLES=2 instance. Inputs are scrambled
  // during WAIT to show only latched values are used.
  task automatic do_req(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_rd);
    req = 1'b1; mem_write = we; address = a; wdata = d;
    tick();
    req = 1'b0; mem_write = ~we; address = 32'hFFFF_FFFC; wdata = 32'h0BAD_F00D;
    chk({tag, " t+1 ready"}, {31'd0, ready}, 32'd0);
    chk({tag, " t+1 busy"},  {31'd0, busy},  32'd1);
    tick();
    chk({tag, " t+2 ready"}, {31'd0, ready}, 32'd0);
    chk({tag, " t+2 busy"},  {31'd0, busy},  32'd1);
    tick();
    chk({tag, " t+3 ready"}, {31'd0, ready}, 32'd1);
    chk({tag, " t+3 err"},   {31'd0, err},   {31'd0, exp_err});
    chk({tag, " t+3 rdata"}, rdata, exp_rd);
    tick();
    chk({tag, " after ready"}, {31'd0, ready}, 32'd0);
    chk({tag, " after err"},   {31'd0, err},   32'd0);
    chk({tag, " after busy"},  {31'd0, busy},  32'd0);
    mem_write = 1'b0; address = 32'd0; wdata = 32'd0;
  endtask

  logic [31:0] busy_addr [8];
  logic        exp_busy  [8];
  logic        exp_ready [8];

  initial begin
    rst_n = 1'b1;
    req = 0; mem_write = 0; address = 0; wdata = 0;
    req0 = 0; mem_write0 = 0; address0 = 0; wdata0 = 0;
    #2 rst_n = 1'b0;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset ready", {31'd0, ready}, 32'd0);
      chk("reset busy",  {31'd0, busy},  32'd0);
      chk("reset rdata", rdata, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle ready", {31'd0, ready}, 32'd0);
      chk("idle busy",  {31'd0, busy},  32'd0);
      chk("idle rdata", rdata, 32'd0);
    end

    // Zero wait states: Ready one cycle after Req
    req0 = 1; mem_write0 = 1; address0 = 32'h0; wdata0 = 32'h1234_5678;
    tick();
    req0 = 0; mem_write0 = 0;
    chk("w0 write ready", {31'd0, ready0}, 32'd1);
    chk("w0 write err",   {31'd0, err0},   32'd0);
    tick();
    chk("w0 write idle",  {31'd0, ready0}, 32'd0);
    chk("w0 write busy",  {31'd0, busy0},  32'd0);
    req0 = 1; mem_write0 = 0; address0 = 32'h0;
    tick();
    req0 = 0;
    chk("w0 read ready", {31'd0, ready0}, 32'd1);
    chk("w0 read rdata", rdata0, 32'h1234_5678);
    tick();
    chk("w0 read idle",  {31'd0, ready0}, 32'd0);

    // Write/read with two wait states
    do_req("wr 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    do_req("rd 0x10", 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF);

    // Error cases
    do_req("rd 0x13 misaligned", 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    do_req("wr 0x0",   1'b1, 32'h0,   32'h1111_1111, 1'b0, 32'h0);
    do_req("wr 0x400 range", 1'b1, 32'h400, 32'hBAD0_BAD0, 1'b1, 32'h0);
    do_req("rd 0x0 after bad wr", 1'b0, 32'h0, 32'h0, 1'b0, 32'h1111_1111);

    // Distinct contents so a wrongly accepted address is visible
    do_req("wr 0x4",  1'b1, 32'h04, 32'h4444_4444, 1'b0, 32'h1111_1111);
    do_req("wr 0x8",  1'b1, 32'h08, 32'h8888_8888, 1'b0, 32'h1111_1111);
    do_req("wr 0xC",  1'b1, 32'h0C, 32'hCCCC_CCCC, 1'b0, 32'h1111_1111);
    do_req("wr 0x14", 1'b1, 32'h14, 32'h1414_1414, 1'b0, 32'h1111_1111);
    do_req("wr 0x18", 1'b1, 32'h18, 32'h1818_1818, 1'b0, 32'h1111_1111);

    // Req held high: only IDLE-cycle addresses (0x4, 0x18) are accepted
    busy_addr = '{32'h04, 32'h08, 32'h0C, 32'h14, 32'h18, 32'h08, 32'h0C, 32'h14};
    exp_busy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      req = 1; mem_write = 0; address = busy_addr[i];
      tick();
      chk($sformatf("held req cycle %0d busy", i + 1),  {31'd0, busy},  {31'd0, exp_busy[i]});
      chk($sformatf("held req cycle %0d ready", i + 1), {31'd0, ready}, {31'd0, exp_ready[i]});
      if (i == 2) chk("held req rdata 0x4",  rdata, 32'h4444_4444);
      if (i == 6) chk("held req rdata 0x18", rdata, 32'h1818_1818);
    end
    req = 0; address = 0;

    // Reset during WAIT aborts the write
    do_req("wr 0x20 prior", 1'b1, 32'h20, 32'h2020_2020, 1'b0, 32'h1818_1818);
    req = 1; mem_write = 1; address = 32'h20; wdata = 32'hA5A5_A5A5;
    tick();
    req = 0; mem_write = 0;
    chk("midop busy before reset", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midop busy in reset",  {31'd0, busy},  32'd0);
    chk("midop ready in reset", {31'd0, ready}, 32'd0);
    chk("midop rdata in reset", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midop no ready", {31'd0, ready}, 32'd0);
    end
    do_req("rd 0x20 after abort", 1'b0, 32'h20, 32'h0, 1'b0, 32'h2020_2020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
